// File: rtl/stage_if.sv
// Instruction fetch: four little-endian byte reads at pc..pc+3, then presents {pc, inst} until consumed.
// Five cycles from S0 to DONE plus one per busy-rejected issue; stall_i holds DONE, rdy=0 freezes everything.
module stage_if #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall_i,
  input  logic              branch_enable_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              mem_busy_i,
  input  logic [7:0]        mem_data_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                pend_q, pend_d;
  logic [3:0][7:0]     buf_q, buf_d;

  logic                issue;
  logic [1:0]          issue_off;
  logic                cap;
  logic [1:0]          cap_idx;
  state_t              state_adv;

  // Per-state decode: which byte offset is issued and which buffer slot the returning byte fills.
  always_comb begin
    issue     = 1'b0;
    issue_off = 2'd0;
    cap       = 1'b0;
    cap_idx   = 2'd0;
    state_adv = S0;
    case (state_q)
      S0: begin issue = 1'b1; issue_off = 2'd0; state_adv = S1; end
      S1: begin issue = 1'b1; issue_off = 2'd1; cap = 1'b1; cap_idx = 2'd0; state_adv = S2; end
      S2: begin issue = 1'b1; issue_off = 2'd2; cap = 1'b1; cap_idx = 2'd1; state_adv = S3; end
      S3: begin issue = 1'b1; issue_off = 2'd3; cap = 1'b1; cap_idx = 2'd2; state_adv = S4; end
      S4: begin cap = 1'b1; cap_idx = 2'd3; state_adv = DONE; end
      default: state_adv = S0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    if (rdy) begin
      if (branch_enable_i) begin
        pc_d    = branch_addr_i;
        state_d = S0;
        pend_d  = 1'b0;
        buf_d   = '0;
      end else if (state_q == DONE) begin
        if (!stall_i) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S0;
        end
      end else begin
        if (cap && pend_q) buf_d[cap_idx] = mem_data_i;
        if (issue) begin
          // A rejected issue leaves nothing in flight, so next cycle's data bus is garbage.
          pend_d = !mem_busy_i;
          if (!mem_busy_i) state_d = state_adv;
        end else begin
          pend_d  = 1'b0;
          state_d = state_adv;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
    end
  end

  // Request is decoded from state only; reset and rdy merely mask it.
  assign mem_req_o    = rst & rdy & issue;
  assign mem_addr_o   = mem_req_o ? (pc_q + ADDR_W'(issue_off)) : '0;
  assign inst_valid_o = (state_q == DONE);
  assign inst_o       = inst_valid_o ? buf_q : 32'h0;
  assign pc_o         = pc_q;

endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. It sits directly upstream of the if_id register and the decode stage.
- Holds the PC and fetches each 32-bit instruction as four byte reads through the shared byte-wide memory arbiter. It assembles the bytes little-endian and presents {pc, inst} with a valid flag.
- Accepts a hold from the pipeline controller and a PC redirect from decode (branch_enable/branch_addr).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC and address width.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global ready; 0 freezes all state.
- stall_i  input  1  downstream hold; 1 means the presented instruction is not consumed.
- branch_enable_i  input  1  redirect request from decode, sampled at the clock edge.
- branch_addr_i  input  ADDR_W  redirect target.
- mem_busy_i  input  1  arbiter busy; 1 means the address issued this cycle is not accepted.
- mem_data_i  input  8  read byte, valid the cycle after an accepted issue.
- mem_req_o  output  1  byte read request.
- mem_addr_o  output  ADDR_W  byte address.
- pc_o  output  ADDR_W  PC of the presented instruction.
- inst_o  output  32  assembled instruction; 32'h0 when not valid (decode treats 0 as a bubble).
- inst_valid_o  output  1  inst_o/pc_o valid.

Behaviour:
- State register pc, FSM state in {S0,S1,S2,S3,S4,DONE}, byte buffer b0..b3, flag pend.
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=S0, pend=0, b0..b3=0.
  - Outputs: mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, pc_o=RESET_PC.
- Issue, in state Sk for k=0..3:
  - mem_req_o=1, mem_addr_o=pc+k (mod 2^ADDR_W).
  - If mem_busy_i=0: issue accepted, pend<=1, state advances to S(k+1).
  - If mem_busy_i=1: state holds and the same address is reissued next cycle; pend<=0.
- Capture, in states S1..S4:
  - If pend=1, the byte on mem_data_i is stored into b(k-1) for state Sk.
  - If pend=0, mem_data_i is ignored.
- S4:
  - mem_req_o=0; capture b3; state <= DONE.
  - S4 never waits on mem_busy_i because it issues nothing.
- DONE:
  - mem_req_o=0, inst_valid_o=1, inst_o={b3,b2,b1,b0}, pc_o=pc.
  - stall_i=1: hold; outputs stable.
  - stall_i=0: instruction consumed at this edge; pc<=pc+4, state<=S0.
- Minimum latency: 5 cycles from S0 entry to DONE, plus 1 cycle per busy-rejected issue. Throughput with no busy and no stall is one instruction per 6 cycles.
- Redirect (branch_enable_i=1 at an edge, any state):
  - pc<=branch_addr_i, state<=S0, pend<=0, buffered bytes discarded.
  - A byte returning in the following cycle is ignored.
  - inst_valid_o=0 from the next cycle.
  - branch_addr_i is used as-is; no alignment check.
- Priority at an edge: rst > rdy=0 > redirect > stall_i > normal advance.
- rdy=0:
  - No state change, including pend, buffered bytes and pc.
  - mem_req_o=0.
  - A byte due that cycle is not captured, and pend stays set. The arbiter freezes its read pipeline under the same rdy, so the byte is re-presented.
- Redirect with stall_i=1 in DONE: redirect wins, and the held instruction is dropped.
- Reset mid-fetch: immediate return to the reset values; no request survives.
- PC arithmetic wraps modulo 2^ADDR_W: 32'hFFFF_FFFC+4 = 0, and byte addresses wrap the same way.
- Outputs are registered or decoded from state only; there is no combinational path from branch_enable_i to mem_req_o.

Test Plan:
- Reset release, memory [0..3]=13,05,A0,00, busy=0, stall=0:
  - Requests at addresses 0,1,2,3 on consecutive cycles.
  - DONE 5 cycles after reset release, with inst_o=32'h00A00513, pc_o=0, valid=1.
  - Next fetch starts at address 4.
- Busy in S2 for 2 cycles:
  - Address 2 is presented 3 times.
  - DONE is reached 2 cycles later than the no-busy case, with the same word; no byte duplicated or shifted.
- stall_i=1 held for 4 cycles in DONE: inst_o, pc_o and valid stay constant, and mem_req_o=0. Release gives pc=4 and address 4 issued.
- Redirect to 32'h100 while in S2:
  - Next cycle: state S0, address 32'h100, valid=0.
  - The word assembled from bytes 0x100..0x103 is correct, with no stale byte from the aborted fetch.
- rdy=0 for 3 cycles in S3 with pend=1: no request, state frozen; after rdy=1, fetch completes with the correct word.
- pc=32'hFFFF_FFFC: addresses FFFF_FFFC..FFFF_FFFF are fetched, then the next fetch is at 0.
